// File: rtl/ftk_burst_tx_pkg.sv
// Shared token types and FSM state encoding for the burst transmitter.
package ftk_burst_tx_pkg;

  localparam int DATA_W = 8;

  typedef struct packed {
    logic              v;
    logic [DATA_W-1:0] d;
  } FTk_t;

  // n is Nack; t/v/c are carried back to the producer untouched.
  typedef struct packed {
    logic n;
    logic t;
    logic v;
    logic c;
  } BTk_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    HOLD = 2'd2,
    DONE = 2'd3
  } state_t;

endpackage

// File: rtl/ftk_burst_tx_ring.sv
// Staging ring: power-of-two FIFO with a combinational head and an occupancy count.
import ftk_burst_tx_pkg::*;

module ftk_burst_tx_ring #(
  parameter int  DEPTH_BUFF = 8,
  parameter type TYPE_FWRD  = FTk_t
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        We,
  input  logic                        Re,
  input  TYPE_FWRD                    I_FTk,
  output TYPE_FWRD                    O_FTk,
  output logic                        O_Full,
  output logic                        O_Empty,
  output logic [$clog2(DEPTH_BUFF):0] O_Num
);

  localparam int AW = $clog2(DEPTH_BUFF);
  localparam logic [AW:0]   NUM_ONE  = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);
  localparam logic [AW:0]   NUM_FULL = (AW+1)'(DEPTH_BUFF);

  TYPE_FWRD      mem [DEPTH_BUFF];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          push;
  logic          pop;

  assign O_Full  = (O_Num == NUM_FULL);
  assign O_Empty = (O_Num == '0);
  assign push    = We & ~O_Full;
  assign pop     = Re & ~O_Empty;
  assign O_FTk   = mem[rd_ptr];

  // Storage carries no reset; only pointers and count define validity.
  always_ff @(posedge clock) begin
    if (push) mem[wr_ptr] <= I_FTk;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      O_Num  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
      case ({push, pop})
        2'b10:   O_Num <= O_Num + NUM_ONE;
        2'b01:   O_Num <= O_Num - NUM_ONE;
        default: O_Num <= O_Num;
      endcase
    end
  end

endmodule

// File: rtl/ftk_burst_tx.sv
// Burst transmitter: stages producer tokens and emits a counted burst, stalling on downstream Nack.
import ftk_burst_tx_pkg::*;

module ftk_burst_tx #(
  parameter int  DEPTH_STAGE = 8,
  parameter int  WIDTH_LEN   = 16,
  parameter int  RESUME_CYC  = 3,
  parameter type TYPE_FWRD   = FTk_t
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 I_Start,
  input  logic [WIDTH_LEN-1:0] I_Len,
  input  TYPE_FWRD             I_FTk,
  output BTk_t                 O_BTk,
  output TYPE_FWRD             O_FTk,
  input  BTk_t                 I_BTk,
  output logic                 O_Busy,
  output logic                 O_Done,
  output logic                 O_Ovf
);

  localparam int CW = $clog2(DEPTH_STAGE) + 1;
  localparam int HW = $clog2(RESUME_CYC + 1);
  localparam logic [CW-1:0]        AF_SET    = CW'(DEPTH_STAGE - 2);
  localparam logic [CW-1:0]        AF_CLR    = CW'(DEPTH_STAGE / 4);
  localparam logic [HW-1:0]        HOLD_LAST = HW'(RESUME_CYC - 1);
  localparam logic [HW-1:0]        HOLD_ONE  = HW'(1);
  localparam logic [WIDTH_LEN-1:0] REM_ONE   = WIDTH_LEN'(1);

  state_t               state;
  logic [WIDTH_LEN-1:0] rem;
  logic [HW-1:0]        hold_cnt;
  logic                 r_afull;
  logic                 emit;
  logic                 we;
  logic                 full;
  logic                 empty;
  logic [CW-1:0]        num;
  TYPE_FWRD             head;

  ftk_burst_tx_ring #(
    .DEPTH_BUFF (DEPTH_STAGE),
    .TYPE_FWRD  (TYPE_FWRD)
  ) u_ring (
    .clock   (clock),
    .reset   (reset),
    .We      (we),
    .Re      (emit),
    .I_FTk   (I_FTk),
    .O_FTk   (head),
    .O_Full  (full),
    .O_Empty (empty),
    .O_Num   (num)
  );

  assign we   = I_FTk.v & ~full;
  // Emit is gated by the live Nack so a stall never loses a token in flight.
  assign emit = (state == SEND) & ~empty & ~I_BTk.n;

  always_comb begin
    O_FTk = '0;
    if (emit) begin
      O_FTk   = head;
      O_FTk.v = 1'b1;
    end
  end

  always_comb begin
    O_BTk   = I_BTk;
    O_BTk.n = r_afull;
  end

  assign O_Busy = (state != IDLE);
  assign O_Done = (state == DONE);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      rem      <= '0;
      hold_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (I_Start) begin
            if (I_Len != '0) begin
              rem   <= I_Len;
              state <= SEND;
            end else begin
              state <= DONE;
            end
          end
        end
        SEND: begin
          if (I_BTk.n) begin
            hold_cnt <= '0;
            state    <= HOLD;
          end else if (emit) begin
            rem <= rem - REM_ONE;
            if (rem == REM_ONE) state <= DONE;
          end
        end
        HOLD: begin
          // Any Nack restarts the quiet window the receiver's filter needs.
          if (I_BTk.n) begin
            hold_cnt <= '0;
          end else begin
            hold_cnt <= hold_cnt + HOLD_ONE;
            if (hold_cnt == HOLD_LAST) state <= SEND;
          end
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Almost-full has hysteresis between DEPTH-2 and DEPTH/4.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_afull <= 1'b0;
      O_Ovf   <= 1'b0;
    end else begin
      if (num >= AF_SET)      r_afull <= 1'b1;
      else if (num <= AF_CLR) r_afull <= 1'b0;
      if (I_FTk.v & full) O_Ovf <= 1'b1;
    end
  end

endmodule

// File: tb/tb_ftk_burst_tx.sv
// Directed bench for ftk_burst_tx with an in-order data scoreboard on emitted tokens.
import ftk_burst_tx_pkg::*;

module tb_ftk_burst_tx;

  logic        clock;
  logic        reset;
  logic        I_Start;
  logic [15:0] I_Len;
  FTk_t        I_FTk;
  BTk_t        O_BTk;
  FTk_t        O_FTk;
  BTk_t        I_BTk;
  logic        O_Busy;
  logic        O_Done;
  logic        O_Ovf;

  int checks = 0;
  int errors = 0;
  logic [7:0] exp_q[$];

  ftk_burst_tx #(
    .DEPTH_STAGE (8),
    .WIDTH_LEN   (16),
    .RESUME_CYC  (3)
  ) dut (
    .clock   (clock),
    .reset   (reset),
    .I_Start (I_Start),
    .I_Len   (I_Len),
    .I_FTk   (I_FTk),
    .O_BTk   (O_BTk),
    .O_FTk   (O_FTk),
    .I_BTk   (I_BTk),
    .O_Busy  (O_Busy),
    .O_Done  (O_Done),
    .O_Ovf   (O_Ovf)
  );

  // Clock and reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Driver tasks
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic push(input logic [7:0] d, input bit accept);
    I_FTk.v = 1'b1;
    I_FTk.d = d;
    if (accept) exp_q.push_back(d);
    tick();
    I_FTk = '0;
  endtask

  task automatic start(input logic [15:0] len);
    I_Start = 1'b1;
    I_Len   = len;
    tick();
    I_Start = 1'b0;
    I_Len   = '0;
  endtask

  task automatic run_basic(input string tag);
    for (int i = 0; i < 4; i++) push(8'h0A + 8'(i), 1'b1);
    start(16'd4);
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      chk({tag, "_v"}, 32'(O_FTk.v), 32'd1);
      chk({tag, "_busy"}, 32'(O_Busy), 32'd1);
      tick();
    end
    @(negedge clock);
    chk({tag, "_done"}, 32'(O_Done), 32'd1);
    chk({tag, "_done_noemit"}, 32'(O_FTk.v), 32'd0);
    tick();
    @(negedge clock);
    chk({tag, "_done_once"}, 32'(O_Done), 32'd0);
    chk({tag, "_idle"}, 32'(O_Busy), 32'd0);
    chk({tag, "_drained"}, 32'(exp_q.size()), 32'd0);
  endtask

  // Scoreboard: every emitted token must be the oldest expected one
  always @(negedge clock) begin
    if (O_FTk.v === 1'b1) begin
      if (exp_q.size() == 0) chk("emit_unexpected", 32'(O_FTk.d), 32'hFFFF_FFFF);
      else                   chk("emit_data", 32'(O_FTk.d), 32'(exp_q.pop_front()));
    end
  end

  initial begin
    reset   = 1'b1;
    I_Start = 1'b0;
    I_Len   = '0;
    I_FTk   = '0;
    I_BTk   = '0;
    #2;
    chk("rst_ftk", 32'(O_FTk), 32'd0);
    chk("rst_busy", 32'(O_Busy), 32'd0);
    chk("rst_done", 32'(O_Done), 32'd0);
    chk("rst_nack", 32'(O_BTk.n), 32'd0);
    chk("rst_ovf", 32'(O_Ovf), 32'd0);
    tick();
    reset = 1'b0;
    tick();

    run_basic("basic");

    // Nack stall after the second emit
    for (int i = 0; i < 6; i++) push(8'h10 + 8'(i), 1'b1);
    start(16'd6);
    for (int i = 0; i < 2; i++) begin
      @(negedge clock);
      chk("stall_pre_v", 32'(O_FTk.v), 32'd1);
      tick();
    end
    I_BTk = '{n: 1'b1, t: 1'b1, v: 1'b0, c: 1'b1};
    @(negedge clock);
    chk("stall_nack_v", 32'(O_FTk.v), 32'd0);
    chk("mirror_t", 32'(O_BTk.t), 32'd1);
    chk("mirror_c", 32'(O_BTk.c), 32'd1);
    chk("mirror_v", 32'(O_BTk.v), 32'd0);
    tick();
    @(negedge clock);
    chk("stall_nack_v", 32'(O_FTk.v), 32'd0);
    chk("stall_busy", 32'(O_Busy), 32'd1);
    tick();
    I_BTk = '0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      chk("stall_quiet_v", 32'(O_FTk.v), 32'd0);
      tick();
    end
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      chk("stall_resume_v", 32'(O_FTk.v), 32'd1);
      tick();
    end
    @(negedge clock);
    chk("stall_done", 32'(O_Done), 32'd1);
    tick();
    @(negedge clock);
    chk("stall_drained", 32'(exp_q.size()), 32'd0);

    // Nack glitch inside HOLD: 0,0,1,0,0,0
    for (int i = 0; i < 3; i++) push(8'h20 + 8'(i), 1'b1);
    start(16'd3);
    @(negedge clock);
    chk("glitch_first_v", 32'(O_FTk.v), 32'd1);
    tick();
    I_BTk.n = 1'b1;
    @(negedge clock);
    chk("glitch_enter_v", 32'(O_FTk.v), 32'd0);
    tick();
    I_BTk.n = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clock);
      chk("glitch_hold_v", 32'(O_FTk.v), 32'd0);
      tick();
    end
    I_BTk.n = 1'b1;
    @(negedge clock);
    chk("glitch_pulse_v", 32'(O_FTk.v), 32'd0);
    tick();
    I_BTk.n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      chk("glitch_rehold_v", 32'(O_FTk.v), 32'd0);
      tick();
    end
    for (int i = 0; i < 2; i++) begin
      @(negedge clock);
      chk("glitch_resume_v", 32'(O_FTk.v), 32'd1);
      tick();
    end
    @(negedge clock);
    chk("glitch_done", 32'(O_Done), 32'd1);
    tick();

    // Staging pressure, almost-full hysteresis and overflow
    for (int k = 1; k <= 8; k++) begin
      push(8'h30 + 8'(k - 1), 1'b1);
      @(negedge clock);
      chk("afull_fill", 32'(O_BTk.n), 32'(k >= 7));
    end
    chk("ovf_before", 32'(O_Ovf), 32'd0);
    push(8'h38, 1'b0);
    @(negedge clock);
    chk("ovf_set", 32'(O_Ovf), 32'd1);
    start(16'd6);
    for (int i = 0; i < 6; i++) begin
      @(negedge clock);
      chk("drain_v", 32'(O_FTk.v), 32'd1);
      chk("drain_afull", 32'(O_BTk.n), 32'd1);
      tick();
    end
    @(negedge clock);
    chk("drain_done", 32'(O_Done), 32'd1);
    chk("drain_afull_hold", 32'(O_BTk.n), 32'd1);
    tick();
    @(negedge clock);
    chk("drain_afull_clr", 32'(O_BTk.n), 32'd0);
    chk("ovf_sticky", 32'(O_Ovf), 32'd1);

    // Start during SEND must not reload the remaining count
    I_Start = 1'b1;
    I_Len   = 16'd2;
    tick();
    I_Len = 16'd5;
    @(negedge clock);
    chk("ign_v0", 32'(O_FTk.v), 32'd1);
    tick();
    I_Start = 1'b0;
    I_Len   = '0;
    @(negedge clock);
    chk("ign_v1", 32'(O_FTk.v), 32'd1);
    tick();
    @(negedge clock);
    chk("ign_done", 32'(O_Done), 32'd1);
    tick();
    @(negedge clock);
    chk("ign_idle", 32'(O_Busy), 32'd0);
    chk("ign_drained", 32'(exp_q.size()), 32'd0);

    // Zero-length burst
    start(16'd0);
    @(negedge clock);
    chk("zero_done", 32'(O_Done), 32'd1);
    chk("zero_noemit", 32'(O_FTk.v), 32'd0);
    chk("zero_busy", 32'(O_Busy), 32'd1);
    tick();
    @(negedge clock);
    chk("zero_done_once", 32'(O_Done), 32'd0);
    chk("zero_idle", 32'(O_Busy), 32'd0);

    // Asynchronous reset mid-burst with three tokens remaining
    for (int i = 0; i < 5; i++) push(8'h40 + 8'(i), 1'b1);
    start(16'd5);
    for (int i = 0; i < 2; i++) begin
      @(negedge clock);
      chk("arst_pre_v", 32'(O_FTk.v), 32'd1);
      tick();
    end
    #2;
    reset = 1'b1;
    #1;
    chk("arst_ftk", 32'(O_FTk), 32'd0);
    chk("arst_busy", 32'(O_Busy), 32'd0);
    chk("arst_nack", 32'(O_BTk.n), 32'd0);
    chk("arst_ovf", 32'(O_Ovf), 32'd0);
    exp_q.delete();
    @(posedge clock);
    @(posedge clock);
    #2;
    reset = 1'b0;
    tick();
    @(negedge clock);
    chk("arst_after_busy", 32'(O_Busy), 32'd0);
    chk("arst_after_v", 32'(O_FTk.v), 32'd0);
    run_basic("post_rst");

    tick();
    tick();
    chk("final_drained", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
